bc_regfile_sb: RTL
==================

Name: bc_regfile_sb

Overview:
Parametrised general-purpose register file with HI/LO special registers, link-register write path and a per-register pending-write scoreboard.
- Read ports are sampled on the falling clock edge; writes commit on the rising edge.
- The scoreboard tracks destinations of in-flight instructions and raises a stall for RAW/WAW hazards.
- Sits between decode (issue side) and writeback in the multicycle/pipelined processor core.

Parameters:
DATA_W, 32, data width of every register, HI, LO
NREGS, 32, number of general registers (power of two, >=4)
ADDR_W, 5, register address width, must equal log2(NREGS)
LINK_REG, 31, index written by loc_write=010 (BL link)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rs  in  ADDR_W  read address, port 1
rt  in  ADDR_W  read address, port 2
rd  in  ADDR_W  write address for loc_write=000
write_data  in  DATA_W  data for GPR/SETHI/SETLO writes
write_hi  in  DATA_W  HI data for loc_write=001
write_lo  in  DATA_W  LO data for loc_write=001
write_ra  in  DATA_W  link data for loc_write=010
reg_write  in  1  writeback enable
loc_write  in  3  write target select
issue_valid  in  1  decode requests issue of an instruction
issue_rd  in  ADDR_W  GPR destination of issuing instruction
issue_wr  in  1  issuing instruction writes issue_rd
issue_hilo  in  1  issuing instruction reads or writes HI/LO
read1  out  DATA_W  registers[rs]
read2  out  DATA_W  registers[rt]
bc_hi  out  DATA_W  HI value
bc_lo  out  DATA_W  LO value
stall  out  1  hazard; issue refused this cycle
busy_vec  out  NREGS  per-GPR pending-write bits

Behaviour:
- Reset (async, rst=1): all GPRs, HI, LO, read1, read2, bc_hi, bc_lo, busy bits and hilo_busy cleared to 0. stall=0. Reset asserted mid-operation discards pending writes and all busy state immediately.
- Writes occur at posedge clk when reg_write=1:
  - 000: reg[rd]=write_data
  - 001: HI=write_hi, LO=write_lo
  - 010: reg[LINK_REG]=write_ra
  - 011: HI=write_data
  - 100: LO=write_data
  - 101-111: no write.
  - reg_write=0: no write and no scoreboard clear.
- Reads: at negedge clk, read1/read2/bc_hi/bc_lo are registered from current storage. A value written at posedge is visible on the outputs at the following negedge, i.e. half-cycle latency. Outputs hold between negedges. rs==rt is legal; both ports return the same value.
- Scoreboard clear (posedge, reg_write=1):
  - 000 clears busy[rd]
  - 010 clears busy[LINK_REG]
  - 001/011/100 clear hilo_busy.
- stall is combinational: issue_valid & (busy[rs] | busy[rt] | (issue_wr & busy[issue_rd]) | (issue_hilo & hilo_busy)).
- Scoreboard set (posedge): if issue_valid & !stall:
  - issue_wr=1 sets busy[issue_rd]
  - issue_hilo=1 sets hilo_busy.
- Same-edge set and clear of the same bit: set wins, so the bit stays 1 (new writer is pending).
- Writeback to a non-busy register is legal; it writes data and leaves the busy bit 0.
- busy_vec mirrors the busy bits and is updated at posedge.

Optional Feature:
BC_REGFILE_ZERO_REG_EN
- Defined: register 0 is hardwired to zero. Writes to index 0 are dropped, busy[0] is never set, and reads of 0 return 0.
- Undefined: register 0 is ordinary storage with a normal scoreboard bit.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> read1, read2, bc_hi, bc_lo, busy_vec all 0 immediately; stall=0.
- GPR write/read: reg_write=1, loc_write=000, rd=5, write_data=0xDEADBEEF at posedge; rs=5 -> read1=0xDEADBEEF at the next negedge; rt=5 gives read2 equal.
- HI/LO paths: loc_write=001 with write_hi=0x1, write_lo=0x2 -> bc_hi=1, bc_lo=2. Then loc_write=011, write_data=0x33 -> bc_hi=0x33 and bc_lo unchanged at 2.
- RAW stall: issue rd=7 (issue_wr=1) accepted, so busy_vec[7]=1. Next cycle issue with rs=7 -> stall=1 and no new busy bit set. Writeback loc_write=000, rd=7 -> busy_vec[7]=0 and stall drops.
- Set/clear collision: busy[9]=1; same posedge has writeback rd=9 and accepted issue rd=9 -> busy_vec[9] remains 1.
- Link and zero register: loc_write=010, write_ra=0x400 -> reg[31]=0x400. With BC_REGFILE_ZERO_REG_EN, write rd=0 data 0xFF -> read1 (rs=0) = 0 and busy_vec[0] stays 0.

Source files
------------

// File: rtl/bc_regfile_sb.sv
// General-purpose register file with HI/LO, link write path and a pending-write scoreboard.
// Optional BC_REGFILE_ZERO_REG_EN: register 0 hardwired to zero with no scoreboard bit.
module bc_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] write_hi,
    input  logic [DATA_W-1:0] write_lo,
    input  logic [DATA_W-1:0] write_ra,
    input  logic              reg_write,
    input  logic [2:0]        loc_write,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_wr,
    input  logic              issue_hilo,
    output logic [DATA_W-1:0] read1,
    output logic [DATA_W-1:0] read2,
    output logic [DATA_W-1:0] bc_hi,
    output logic [DATA_W-1:0] bc_lo,
    output logic              stall,
    output logic [NREGS-1:0]  busy_vec
);

    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;
    logic              hilo_busy;
    logic              hilo_busy_next;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
`ifdef BC_REGFILE_ZERO_REG_EN
        return (a == {ADDR_W{1'b0}});
`else
        return 1'b0;
`endif
    endfunction

    assign stall = issue_valid & (busy[rs] | busy[rt] | (issue_wr & busy[issue_rd]) |
                                  (issue_hilo & hilo_busy));
    assign busy_vec = busy;

    // Storage writes from writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= {DATA_W{1'b0}};
            end
            hi <= {DATA_W{1'b0}};
            lo <= {DATA_W{1'b0}};
        end else if (reg_write) begin
            case (loc_write)
                3'b000: if (!is_zero(rd)) regs[rd] <= write_data;
                3'b001: begin
                    hi <= write_hi;
                    lo <= write_lo;
                end
                3'b010: if (!is_zero(LINK_IDX)) regs[LINK_IDX] <= write_ra;
                3'b011: hi <= write_data;
                3'b100: lo <= write_data;
                default: ;
            endcase
        end
    end

    // Scoreboard next state: writeback clears first, then an accepted issue sets (set wins).
    always_comb begin
        busy_next      = busy;
        hilo_busy_next = hilo_busy;
        if (reg_write) begin
            case (loc_write)
                3'b000:  busy_next[rd] = 1'b0;
                3'b010:  busy_next[LINK_IDX] = 1'b0;
                3'b001,
                3'b011,
                3'b100:  hilo_busy_next = 1'b0;
                default: hilo_busy_next = hilo_busy;
            endcase
        end else begin
            hilo_busy_next = hilo_busy;
        end
        if (issue_valid && !stall) begin
            if (issue_wr && !is_zero(issue_rd)) begin
                busy_next[issue_rd] = 1'b1;
            end else begin
                busy_next = busy_next;
            end
            if (issue_hilo) begin
                hilo_busy_next = 1'b1;
            end else begin
                hilo_busy_next = hilo_busy_next;
            end
        end else begin
            busy_next = busy_next;
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= {NREGS{1'b0}};
            hilo_busy <= 1'b0;
        end else begin
            busy      <= busy_next;
            hilo_busy <= hilo_busy_next;
        end
    end

    // Read ports sampled on the falling edge, giving half-cycle write-to-read latency.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            read1 <= {DATA_W{1'b0}};
            read2 <= {DATA_W{1'b0}};
            bc_hi <= {DATA_W{1'b0}};
            bc_lo <= {DATA_W{1'b0}};
        end else begin
            read1 <= is_zero(rs) ? {DATA_W{1'b0}} : regs[rs];
            read2 <= is_zero(rt) ? {DATA_W{1'b0}} : regs[rt];
            bc_hi <= hi;
            bc_lo <= lo;
        end
    end

endmodule
